aes_core_arbiter: RTL and testbench
===================================

# aes_core_arbiter

Shares one iterative AES-128 encryption core between two requesters. The block handles request handshakes and round-robin arbitration, and starts the core by pulsing its reset with the operands held stable. It then waits for the core's done flag, with a watchdog, and returns the ciphertext to the owning requester over a valid/ready response channel. It sits between the two client ports and the single core instance.

## Interface

- TIMEOUT_CYC, 32, max RUN cycles allowed before the operation is aborted with error (>= 16)
- CNT_W, 16, width of completed-operation counter

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_din0, req_din1  in  128 each  plaintext for requester 0 / 1
- req_key0, req_key1  in  128 each  key for requester 0 / 1
- req_ready  out  2  per-requester accept; at most one bit high
- rsp_valid  out  2  per-requester response valid; at most one bit high
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  128  ciphertext, shared by both requesters
- rsp_err  out  1  response is a timeout abort; rsp_data = 0
- core_rst  out  1  reset/start to core: high = core held idle, falling edge = start
- core_din, core_key  out  128 each  operands to core; held stable from LOAD until RESP
- core_ctxt  in  128  core result
- core_done  in  1  core completion flag
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  count of successful (non-error) responses, wraps

## Operation

- States: IDLE, LOAD, RUN, RESP.
- IDLE
  - Grant is combinational from req_valid and the last_grant register.
  - If only one requester is valid, it wins. If both are valid, the winner is the requester != last_grant.
  - req_ready[winner] = 1.
  - On handshake: latch din/key into core_din/core_key, set owner = winner, set last_grant = winner, go LOAD.
- LOAD: core_rst = 1 for exactly one cycle; next state RUN. Clear the watchdog counter.
- RUN
  - core_rst = 0. Watchdog increments every cycle.
  - core_done is ignored in the first RUN cycle. The core clears a stale done only on the first clock after core_rst falls.
  - From the second RUN cycle: core_done = 1 → rsp_data <= core_ctxt, rsp_err <= 0, go RESP.
  - Watchdog reaches TIMEOUT_CYC without done → rsp_data <= 0, rsp_err <= 1, go RESP.
  - Done and timeout in the same cycle: done wins.
- RESP
  - rsp_valid[owner] = 1. rsp_data and rsp_err are stable until the handshake.
  - rsp_ready[owner] & rsp_valid → go IDLE. If !rsp_err, increment ops_done (wraps to 0 at all-ones).
  - rsp_ready on the non-owner bit is ignored.
- core_rst = reset | (state == LOAD). The core is held idle throughout reset.
- req_valid changes outside IDLE are ignored. No request is accepted while busy.

## Timing

- Reset values:
  - State IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - core_din = core_key = 0, busy = 0, ops_done = 0.
  - last_grant = 1, so requester 0 wins the first contested grant.
  - core_rst = 1 while reset is high.
- Reset mid-operation: abandon the operation at the next edge. No response is issued. ops_done clears.
- Latency from request handshake edge, with the standard core (done 11 cycles after core_rst falls):
  - LOAD occupies cycle 1.
  - core_done is seen in cycle 12.
  - rsp_valid rises on the cycle-13 edge.
  - With rsp_ready held high: 14 cycles per operation handshake-to-handshake.
  - The next req_ready is available in the cycle after the response handshake.
- Back-to-back with both requesters valid, grants alternate 0,1,0,1…
- ops_done updates on the same edge as the response handshake.

## Test plan

- FIPS-197 vector on requester 0:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: rsp_valid = 2'b01, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err = 0, ops_done = 1, 14-cycle turnaround.
- Contention: both req_valid high continuously with different plaintexts.
  - Required: grants 0,1,0,1. Each response goes to the correct owner with the correct ciphertext. ops_done = 4 after four responses.
- Response backpressure: rsp_ready low for 20 cycles.
  - Required: rsp_valid, rsp_data and rsp_err stay stable, req_ready = 0, and busy = 1 until the handshake.
- Stale done: core_done stub stuck at 1 from the previous operation.
  - Required: the first RUN cycle does not complete. Completion occurs on the second RUN cycle with the stub's ctxt.
- Timeout: core model never asserts done.
  - Required: after 32 RUN cycles, rsp_err = 1, rsp_data = 0, and ops_done is unchanged.
- Reset in RUN cycle 5:
  - Required: all outputs return to reset values.
  - No rsp_valid is issued.
  - Requester 0 is granted first on a subsequent contested request.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one iterative AES-128 core between two requesters.
// Round-robin grant, core start via a one-cycle reset pulse, watchdog on the
// core's done flag, and a valid/ready response channel back to the owner.
//
//   state | meaning
//   IDLE  | waiting for a request; grant is combinational
//   LOAD  | operands latched, core held in reset for one cycle
//   RUN   | core running; watchdog counting, done ignored on first cycle
//   RESP  | result held on the response channel until the owner accepts
module aes_core_arbiter #(
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req_valid,
  input  logic [127:0]     i_req_din0,
  input  logic [127:0]     i_req_din1,
  input  logic [127:0]     i_req_key0,
  input  logic [127:0]     i_req_key1,
  output logic [1:0]       o_req_ready,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [127:0]     o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_core_rst,
  output logic [127:0]     o_core_din,
  output logic [127:0]     o_core_key,
  input  logic [127:0]     i_core_ctxt,
  input  logic             i_core_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_ops_done
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_owner;
  logic [127:0]     r_core_din;
  logic [127:0]     r_core_key;
  logic [127:0]     r_rsp_data;
  logic             r_rsp_err;
  logic [WD_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_win;
  logic             w_accept;
  logic             w_done_hit;
  logic             w_timeout_hit;
  logic             w_rsp_hs;

  // Contested grant goes to the requester that did not win last time.
  assign w_win = (i_req_valid == 2'b11) ? ~r_last_grant : ~i_req_valid[0];

  // Next-state decode plus handshake outputs; nothing is offered while reset is high.
  always_comb begin
    w_state_nxt   = r_state;
    o_req_ready   = 2'b00;
    o_rsp_valid   = 2'b00;
    w_accept      = 1'b0;
    w_done_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    w_rsp_hs      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_reset && (i_req_valid != 2'b00)) begin
          o_req_ready = w_win ? 2'b10 : 2'b01;
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A done seen in the first RUN cycle may be stale from the last operation.
        if ((r_wdog != '0) && i_core_done) begin
          w_done_hit  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        if (!i_reset) begin
          o_rsp_valid = r_owner ? 2'b10 : 2'b01;
          if (i_rsp_ready[r_owner]) begin
            w_rsp_hs    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Operand latch, ownership, watchdog, response capture and success counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_core_din   <= '0;
      r_core_key   <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_wdog       <= '0;
      r_ops_done   <= '0;
    end else begin
      if (w_accept) begin
        r_core_din   <= w_win ? i_req_din1 : i_req_din0;
        r_core_key   <= w_win ? i_req_key1 : i_req_key0;
        r_owner      <= w_win;
        r_last_grant <= w_win;
      end
      if (r_state == S_LOAD)     r_wdog <= '0;
      else if (r_state == S_RUN) r_wdog <= r_wdog + 1'b1;
      if (w_done_hit) begin
        r_rsp_data <= i_core_ctxt;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout_hit) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
      if (w_rsp_hs && !r_rsp_err) r_ops_done <= r_ops_done + 1'b1;
    end
  end

  assign o_core_rst = i_reset | (r_state == S_LOAD);
  assign o_core_din = r_core_din;
  assign o_core_key = r_core_key;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;
  assign o_busy     = (r_state != S_IDLE);
  assign o_ops_done = r_ops_done;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural core stub plus a transaction-level
// reference model of grant order, latency, response contents and the counter.
module tb_aes_core_arbiter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [127:0] req_din0, req_din1, req_key0, req_key1;
  logic [1:0]   req_ready, rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err, core_rst, core_done, busy;
  logic [127:0] core_din, core_key, core_ctxt;
  logic [15:0]  ops_done;

  always #5 clk = ~clk;

  aes_core_arbiter #(.TIMEOUT_CYC(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid),
    .i_req_din0(req_din0), .i_req_din1(req_din1),
    .i_req_key0(req_key0), .i_req_key1(req_key1),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_core_rst(core_rst),
    .o_core_din(core_din), .o_core_key(core_key), .i_core_ctxt(core_ctxt),
    .i_core_done(core_done), .o_busy(busy), .o_ops_done(ops_done)
  );

  // Core stand-in: known-answer table for the FIPS vector, simple mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  // Core stub: done rises core_lat clocks after start, sticks until the first
  // clock after the next start; core_stuck forces done permanently high.
  int   core_lat = 10;
  bit   core_stuck = 1'b0;
  int   core_cnt = 0;
  logic core_done_r = 1'b0;
  always @(posedge clk) begin
    if (core_rst) core_cnt <= 0;
    else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == core_lat) core_done_r <= 1'b1;
      else if (core_cnt == 0)       core_done_r <= 1'b0;
    end
  end
  assign core_done = core_stuck | core_done_r;
  assign core_ctxt = core_fn(core_din, core_key);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  bit          m_last = 1'b1;
  logic [15:0] m_ops = '0;
  bit          turn_ok = 1'b0;
  int          t_hs = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic do_op(input logic [1:0] v, input int lat, input bit stuck,
                       input int rdy_dly, input bit fips);
    logic [127:0] d0, d1, k0, k1, exp_data;
    bit win, exp_err, stable;
    int exp_lat, n;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    k0 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    if (fips) begin d0 = FIPS_PT; k0 = FIPS_KEY; end
    core_lat = lat; core_stuck = stuck;
    req_din0 = d0; req_din1 = d1; req_key0 = k0; req_key1 = k1;
    req_valid = v;
    win      = (v == 2'b11) ? !m_last : (v == 2'b10);
    exp_err  = !stuck && (lat > 31);
    exp_lat  = stuck ? 3 : ((lat <= 31) ? lat + 2 : 33);
    exp_data = exp_err ? 128'h0 : core_fn(win ? d1 : d0, win ? k1 : k0);
    #1;
    chk("req_ready", req_ready, win ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    if (turn_ok) chk("turnaround", cyc - t_hs, 14);
    t_hs = cyc;
    m_last = win;
    chk("core_rst_load", core_rst, 1'b1);
    chk("core_din", core_din, win ? d1 : d0);
    chk("core_key", core_key, win ? k1 : k0);
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      @(posedge clk); #1; n++;
      req_valid = 2'($urandom_range(0, 3));
      if (n == 1) chk("core_rst_run", core_rst, 1'b0);
    end
    chk("latency", n, exp_lat);
    chk("rsp_valid", rsp_valid, win ? 2'b10 : 2'b01);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);
    stable = 1'b1;
    rsp_ready = win ? 2'b01 : 2'b10;
    for (int i = 0; i < rdy_dly; i++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      if (rsp_valid !== (win ? 2'b10 : 2'b01) || rsp_data !== exp_data ||
          rsp_err !== exp_err || busy !== 1'b1 || req_ready !== 2'b00) stable = 1'b0;
    end
    if (rdy_dly > 0) chk("rsp_hold", stable, 1'b1);
    rsp_ready = win ? 2'b10 : 2'b01;
    @(posedge clk);
    if (!exp_err) m_ops++;
    #1;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    chk("ops_done", ops_done, m_ops);
    chk("busy_after", busy, 1'b0);
    chk("rsp_valid_after", rsp_valid, 2'b00);
    turn_ok = (lat == 10) && !stuck && (rdy_dly == 0);
  endtask

  task automatic reset_in_run();
    bit quiet;
    req_valid = 2'b01;
    req_din0 = {$urandom, $urandom, $urandom, $urandom};
    req_key0 = {$urandom, $urandom, $urandom, $urandom};
    core_lat = 10; core_stuck = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("rst_core_rst", core_rst, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 128'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_ops_done", ops_done, 16'h0);
    chk("rst_core_din", core_din, 128'h0);
    chk("rst_core_key", core_key, 128'h0);
    quiet = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("rst_no_rsp", quiet, 1'b1);
    m_last = 1'b1; m_ops = '0; turn_ok = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_chk);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_din0 = '0; req_din1 = '0; req_key0 = '0; req_key1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_core_rst", core_rst, 1'b1);
    chk("init_req_ready", req_ready, 2'b00);
    chk("init_busy", busy, 1'b0);
    chk("init_rsp_valid", rsp_valid, 2'b00);
    chk("init_rsp_data", rsp_data, 128'h0);
    chk("init_ops_done", ops_done, 16'h0);
    chk("init_core_din", core_din, 128'h0);
    req_valid = 2'b00;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_core_rst", core_rst, 1'b0);

    do_op(2'b01, 10, 1'b0, 0, 1'b1);
    repeat (4) do_op(2'b11, 10, 1'b0, 0, 1'b0);
    do_op(2'b10, 10, 1'b0, 20, 1'b0);
    do_op(2'b01, 10, 1'b1, 0, 1'b0);
    do_op(2'b10, 60, 1'b0, 3, 1'b0);
    do_op(2'b01, 31, 1'b0, 0, 1'b0);
    do_op(2'b01, 32, 1'b0, 0, 1'b0);
    do_op(2'b11, 1, 1'b0, 0, 1'b0);
    reset_in_run();
    do_op(2'b11, 10, 1'b0, 0, 1'b0);
    for (int i = 0; i < 30; i++)
      do_op(2'($urandom_range(1, 3)), $urandom_range(1, 40),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 4), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
